// File: rtl/ibex_mprf_pkg.sv
// Shared types and constants for the MPRF descriptor transmit path.
package ibex_mprf_pkg;

  localparam int unsigned MprfAddrWidth = 10;
  localparam int unsigned MprfDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DROP
  } tx_state_e;

  typedef struct packed {
    logic                     head;
    logic                     tail;
    logic [MprfAddrWidth-1:0] addr;
    logic [MprfDataWidth-1:0] data;
  } noc_flit_t;

endpackage

// File: rtl/ibex_mprf_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; the caller guarantees legal push/pop.
module ibex_mprf_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 44
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   free_cnt
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [PtrW:0]      used;
  logic [Width-1:0]   mem_reg [Depth];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_reg[wr_ptr_reg[PtrW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign rdata    = mem_reg[rd_ptr_reg[PtrW-1:0]];
  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign free_cnt = (PtrW+1)'(Depth) - used;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                    (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);

endmodule

// File: rtl/ibex_mprf_noc_tx.sv
// Packetizes the non-stallable descriptor beat stream into head/tail framed NoC flits,
// reserving the last FIFO slot for a forced tail and counting beats that cannot be kept.
module ibex_mprf_noc_tx
  import ibex_mprf_pkg::*;
#(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = MprfAddrWidth,
  parameter int unsigned MaxBurst  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           desc_en_i,
  input  logic [DataWidth-1:0]           desc_data_i,
  input  logic [AddrWidth-1:0]           desc_addr_i,
  output logic                           noc_valid_o,
  input  logic                           noc_ready_i,
  output logic [DataWidth+AddrWidth+1:0] noc_flit_o,
  output logic                           almost_full_o,
  output logic                           overflow_o,
  output logic [7:0]                     drop_cnt_o,
  input  logic                           clear_i,
  output logic                           busy_o
);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned FlitW  = DataWidth + AddrWidth + 2;
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);

  tx_state_e              state_reg, state_next;
  logic                   stage_valid_reg;
  logic [DataWidth-1:0]   stage_data_reg;
  logic [AddrWidth-1:0]   stage_addr_reg;
  logic [BurstW-1:0]      burst_cnt_reg, burst_cnt_next;
  logic                   overflow_reg;
  logic [7:0]             drop_cnt_reg;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FlitW-1:0]       fifo_wdata, fifo_rdata;
  logic [PtrW:0]          free_cnt;
  logic [PtrW+1:0]        free_eff;
  logic                   head, tail, drop, last_beat;

  assign fifo_pop  = !fifo_empty && noc_ready_i;
  // Reservation sees the slot freed by a same-cycle pop.
  assign free_eff  = {1'b0, free_cnt} + {{(PtrW+1){1'b0}}, fifo_pop};
  assign head      = (burst_cnt_reg == '0);
  assign last_beat = (burst_cnt_reg == BurstW'(MaxBurst - 1));

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    fifo_push      = 1'b0;
    tail           = 1'b0;
    drop           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (desc_en_i) state_next = BURST;
      end
      BURST: begin
        if (stage_valid_reg) begin
          if (free_eff >= (PtrW+2)'(2)) begin
            fifo_push = 1'b1;
            tail      = !desc_en_i || last_beat;
          end else if (free_eff == (PtrW+2)'(1)) begin
            fifo_push = 1'b1;
            tail      = 1'b1;
          end else begin
            drop = 1'b1;
          end
          if (!desc_en_i) begin
            state_next = IDLE;
          end else if (free_eff < (PtrW+2)'(2)) begin
            state_next = DROP;
          end
          burst_cnt_next = (tail || drop) ? '0 : burst_cnt_reg + 1'b1;
        end
      end
      DROP: begin
        if (stage_valid_reg) begin
          drop = 1'b1;
          if (!desc_en_i) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_wdata = {head, tail, stage_addr_reg, stage_data_reg};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      stage_valid_reg <= 1'b0;
      stage_data_reg  <= '0;
      stage_addr_reg  <= '0;
      burst_cnt_reg   <= '0;
      overflow_reg    <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      burst_cnt_reg   <= burst_cnt_next;
      stage_valid_reg <= desc_en_i;
      if (desc_en_i) begin
        stage_data_reg <= desc_data_i;
        stage_addr_reg <= desc_addr_i;
      end
      if (clear_i) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hff) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  ibex_mprf_fifo #(
    .Depth (Depth),
    .Width (FlitW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (fifo_push),
    .wdata    (fifo_wdata),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  assign noc_valid_o   = !fifo_empty;
  assign noc_flit_o    = fifo_empty ? '0 : fifo_rdata;
  assign almost_full_o = fifo_full || (free_cnt == (PtrW+1)'(1));
  assign overflow_o    = overflow_reg;
  assign drop_cnt_o    = drop_cnt_reg;
  assign busy_o        = stage_valid_reg || !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_ibex_mprf_noc_tx.sv
// Directed and randomized checks of the NoC transmit packetizer against a queue-based model.
module tb_ibex_mprf_noc_tx;
  localparam int Depth    = 8;
  localparam int DW       = 32;
  localparam int AW       = 10;
  localparam int MaxBurst = 16;
  localparam int FW       = DW + AW + 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          desc_en_i = 1'b0;
  logic [DW-1:0] desc_data_i = '0;
  logic [AW-1:0] desc_addr_i = '0;
  logic          noc_ready_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          noc_valid_o;
  logic [FW-1:0] noc_flit_o;
  logic          almost_full_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  ibex_mprf_noc_tx #(
    .Depth(Depth), .DataWidth(DW), .AddrWidth(AW), .MaxBurst(MaxBurst)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .desc_en_i(desc_en_i), .desc_data_i(desc_data_i),
    .desc_addr_i(desc_addr_i), .noc_valid_o(noc_valid_o), .noc_ready_i(noc_ready_i),
    .noc_flit_o(noc_flit_o), .almost_full_o(almost_full_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .clear_i(clear_i), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: expected flit queue, previous-cycle beat, position in packet, drop mode.
  logic [FW-1:0] mq[$];
  bit            m_prev;
  logic [DW-1:0] m_pdata;
  logic [AW-1:0] m_paddr;
  int            m_len;
  bit            m_dropping;
  bit            m_ovf;
  int            m_drop;

  logic [FW-1:0] got[$];
  int            got_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] fl(input bit h, input bit t, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    return {h, t, a, d};
  endfunction

  function automatic bit fhead(input logic [FW-1:0] f);
    return f[FW-1];
  endfunction

  function automatic bit ftail(input logic [FW-1:0] f);
    return f[FW-2];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_prev = 0; m_len = 0; m_dropping = 0; m_ovf = 0; m_drop = 0;
    m_pdata = '0; m_paddr = '0;
  endtask

  task automatic model_step();
    bit pop, drop, push, t;
    int free;
    logic [FW-1:0] f;
    pop  = (mq.size() > 0) && noc_ready_i;
    free = Depth - mq.size() + (pop ? 1 : 0);
    drop = 0; push = 0; f = '0;
    if (m_prev) begin
      if (m_dropping || free == 0) begin
        drop = 1; m_dropping = 1; m_len = 0;
      end else begin
        t = !desc_en_i || (m_len + 1 == MaxBurst) || (free == 1);
        f = fl(m_len == 0, t, m_paddr, m_pdata);
        push = 1;
        if (free == 1) m_dropping = 1;
        m_len = t ? 0 : m_len + 1;
      end
      if (!desc_en_i) m_dropping = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(f);
    if (clear_i) begin
      m_ovf = 0; m_drop = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    m_prev  = desc_en_i;
    m_pdata = desc_data_i;
    m_paddr = desc_addr_i;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // Per-cycle compare against the model, plus capture of accepted flits.
  initial begin
    forever begin
      @(negedge clk_i);
      check("valid", noc_valid_o, mq.size() > 0);
      if (mq.size() > 0) check("flit", noc_flit_o, mq[0]);
      check("almost_full", almost_full_o, (Depth - mq.size()) < 2);
      check("overflow", overflow_o, m_ovf);
      check("drop_cnt", drop_cnt_o, m_drop);
      check("busy", busy_o, m_prev || (mq.size() > 0));
      if (rst_ni && noc_valid_o && noc_ready_i) begin
        got.push_back(noc_flit_o);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    desc_en_i = 1; desc_addr_i = a; desc_data_i = d;
    tick();
  endtask

  task automatic idle(input int n);
    desc_en_i = 0;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, noc_valid_o, 0);
    check({tag, "_flit"}, noc_flit_o, 0);
    check({tag, "_af"}, almost_full_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_dcnt"}, drop_cnt_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    int c0, nh, nt, ready_pct, run_left, clr_en;
    logic [FW-1:0] held;

    #2 rst_ni = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    tick();
    rst_ni = 1;
    tick();

    // Three beats, ready high.
    noc_ready_i = 1; got.delete(); got_cyc.delete();
    c0 = cyc;
    beat(10'h010, 32'hAAAA_0001);
    beat(10'h011, 32'hBBBB_0002);
    beat(10'h012, 32'hCCCC_0003);
    idle(6);
    check("three_cnt", got.size(), 3);
    if (got.size() == 3) begin
      check("three_f0", got[0], fl(1, 0, 10'h010, 32'hAAAA_0001));
      check("three_f1", got[1], fl(0, 0, 10'h011, 32'hBBBB_0002));
      check("three_f2", got[2], fl(0, 1, 10'h012, 32'hCCCC_0003));
      check("three_lat0", got_cyc[0], c0 + 2);
      check("three_lat2", got_cyc[2], c0 + 4);
    end

    // Single beat.
    got.delete(); got_cyc.delete();
    beat(10'h3ff, 32'hDEAD_BEEF);
    idle(4);
    check("single_cnt", got.size(), 1);
    if (got.size() == 1) check("single_f", got[0], fl(1, 1, 10'h3ff, 32'hDEAD_BEEF));

    // 20-beat run split at MaxBurst.
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 20; i++) beat(AW'(10'h100 + i), DW'(i));
    idle(6);
    check("split_cnt", got.size(), 20);
    if (got.size() == 20) begin
      check("split_f0", got[0], fl(1, 0, 10'h100, 32'd0));
      check("split_f15", got[15], fl(0, 1, 10'h10f, 32'd15));
      check("split_f16", got[16], fl(1, 0, 10'h110, 32'd16));
      check("split_f19", got[19], fl(0, 1, 10'h113, 32'd19));
      nh = 0; nt = 0;
      foreach (got[i]) begin
        nh += fhead(got[i]);
        nt += ftail(got[i]);
      end
      check("split_heads", nh, 2);
      check("split_tails", nt, 2);
    end

    // Overflow: 12 beats into an 8-deep FIFO with ready low.
    noc_ready_i = 0; got.delete(); got_cyc.delete();
    for (int i = 0; i < 12; i++) beat(AW'(10'h200 + i), DW'(32'h5000 + i));
    idle(3);
    @(negedge clk_i);
    check("ovf_dcnt", drop_cnt_o, 4);
    check("ovf_flag", overflow_o, 1);
    check("ovf_af", almost_full_o, 1);
    tick();
    noc_ready_i = 1;
    idle(12);
    check("ovf_cnt", got.size(), 8);
    if (got.size() == 8) begin
      check("ovf_f0", got[0], fl(1, 0, 10'h200, 32'h5000));
      check("ovf_f6_tail", ftail(got[6]), 0);
      check("ovf_f7", got[7], fl(0, 1, 10'h207, 32'h5007));
    end
    clear_i = 1;
    tick();
    clear_i = 0;
    @(negedge clk_i);
    check("clr_ovf", overflow_o, 0);
    check("clr_dcnt", drop_cnt_o, 0);
    tick();

    // Flit held under backpressure.
    noc_ready_i = 0; got.delete(); got_cyc.delete();
    beat(10'h055, 32'h1234_5678);
    idle(1);
    @(negedge clk_i);
    held = noc_flit_o;
    check("hold_first", held, fl(1, 1, 10'h055, 32'h1234_5678));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk_i);
      check("hold_stable", noc_flit_o, fl(1, 1, 10'h055, 32'h1234_5678));
      check("hold_valid", noc_valid_o, 1);
    end
    tick();
    noc_ready_i = 1;
    tick();
    @(negedge clk_i);
    check("hold_popped", got.size(), 1);
    check("hold_empty", noc_valid_o, 0);
    tick();

    // Reset mid-burst.
    noc_ready_i = 0;
    beat(10'h060, 32'h1);
    beat(10'h061, 32'h2);
    beat(10'h062, 32'h3);
    rst_ni = 0; desc_en_i = 0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    tick();
    rst_ni = 1;
    tick();
    noc_ready_i = 1; got.delete(); got_cyc.delete();
    beat(10'h077, 32'hCAFE_F00D);
    idle(4);
    check("post_rst_cnt", got.size(), 1);
    if (got.size() == 1) check("post_rst_f", got[0], fl(1, 1, 10'h077, 32'hCAFE_F00D));

    // Randomized traffic, phases of varying backpressure; one long no-clear phase saturates the counter.
    run_left = 0;
    for (int ph = 0; ph < 7; ph++) begin
      case (ph)
        0: ready_pct = 100;
        1: ready_pct = 70;
        2: ready_pct = 30;
        3: ready_pct = 0;
        4: ready_pct = 10;
        5: ready_pct = 90;
        default: ready_pct = 50;
      endcase
      clr_en = (ph != 3);
      for (int i = 0; i < (ph == 3 ? 700 : 500); i++) begin
        if (run_left > 0) begin
          desc_en_i = 1;
          run_left--;
        end else if ($urandom_range(0, 2) != 0) begin
          desc_en_i = 1;
          run_left = $urandom_range(0, 23);
        end else begin
          desc_en_i = 0;
        end
        desc_data_i = $urandom;
        desc_addr_i = AW'($urandom);
        noc_ready_i = ($urandom_range(0, 99) < ready_pct);
        clear_i = clr_en && ($urandom_range(0, 199) == 0);
        tick();
      end
      if (ph == 3) begin
        @(negedge clk_i);
        check("sat_dcnt", drop_cnt_o, 255);
      end
    end
    clear_i = 0; noc_ready_i = 1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
